rr_stream_mux: RTL and testbench

- N-channel, W-bit registered stream multiplexer with valid/ready handshake on every input and on the output.
- Generalises the 2:1 select mux: parametrised channel count and width, two selection modes (round-robin, external select), and packet locking via a last flag.
- Sits between multiple producers and a single consumer; one output register stage.

---
 rtl/stream_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/rr_stream_mux.sv | 155 +++++++++++++++
 tb/tb_rr_stream_mux.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_pkg
// Purpose  : Shared encodings for the stream multiplexer: packet-lock state
//            and arbitration mode constants.
// Revision : 1.0 - initial release
// ============================================================================
package stream_pkg;

  // Packet-lock state: IDLE arbitrates freely, LOCKED pins the grant to one
  // channel until that channel delivers its last beat.
  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational rotate-priority search. Returns the first request
//            found scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [SW-1:0] gnt_idx,
  output logic          any
);

  // Walk the channels starting at ptr; the first requester wins.
  always_comb begin
    int idx;
    idx     = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any && req[idx]) begin
        any         = 1'b1;
        gnt_idx     = SW'(idx);
        gnt_oh[idx] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux
// Purpose  : N-channel registered stream multiplexer with valid/ready on
//            every port, round-robin or externally selected arbitration, and
//            packet locking on the last flag. One output register stage.
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_mux
  import stream_pkg::*;
#(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int MODE = 0,
  parameter int SW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SW-1:0]   sel,
  input  logic [N-1:0]    in_valid,
  input  logic [N-1:0]    in_last,
  input  logic [N*W-1:0]  in_data,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_last,
  output logic [SW-1:0]   out_chan,
  input  logic            out_ready
);

  state_e        state_q, state_d;
  logic [SW-1:0] lock_q, lock_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [SW-1:0] out_chan_q, out_chan_d;

  logic          load_en;
  logic          xfer;
  logic          gnt_valid;
  logic [SW-1:0] gnt_idx;
  logic [N-1:0]  gnt_oh;
  logic          beat_last;
  logic [W-1:0]  beat_data;

  logic [N-1:0]  arb_oh;
  logic [SW-1:0] arb_idx;
  logic          arb_any;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  // The output register may take a beat whenever it is empty or draining.
  assign load_en = !out_valid_q || out_ready;

  // Grant selection: a held packet owns the mux; otherwise sel or round-robin.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    gnt_oh    = '0;
    if (state_q == LOCKED) begin
      gnt_idx        = lock_q;
      gnt_valid      = in_valid[lock_q];
      gnt_oh[lock_q] = 1'b1;
    end else if (MODE == MODE_FIXED) begin
      // Out-of-range select values simply grant nobody.
      if (int'(sel) < N) begin
        gnt_idx     = sel;
        gnt_valid   = in_valid[sel];
        gnt_oh[sel] = 1'b1;
      end
    end else begin
      gnt_idx   = arb_idx;
      gnt_valid = arb_any;
      gnt_oh    = arb_oh;
    end
  end

  assign xfer      = load_en && gnt_valid;
  assign in_ready  = xfer ? (gnt_oh & in_valid) : '0;
  assign beat_data = in_data[int'(gnt_idx)*W +: W];
  assign beat_last = in_last[gnt_idx];

  // Next-state: packet lock, round-robin pointer and output register loading.
  always_comb begin
    state_d     = state_q;
    lock_d      = lock_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_chan_d  = out_chan_q;

    if (xfer) begin
      if (state_q == IDLE && !beat_last) begin
        state_d = LOCKED;
        lock_d  = gnt_idx;
      end else if (state_q == LOCKED && beat_last) begin
        state_d = IDLE;
      end
      // The pointer only advances at packet boundaries so a packet's
      // successor is the channel after its source.
      if (beat_last) begin
        ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + SW'(1);
      end
    end

    if (load_en) begin
      out_valid_d = xfer;
      // Data fields keep their last value when nothing new is loaded.
      if (xfer) begin
        out_data_d = beat_data;
        out_last_d = beat_last;
        out_chan_d = gnt_idx;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_q      <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_chan_q  <= '0;
    end else begin
      state_q     <= state_d;
      lock_q      <= lock_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_chan  = out_chan_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_mux
// Purpose  : Scoreboard bench for rr_stream_mux. One instance in round-robin
//            mode, one in fixed-select mode; stimulus pushes hand-computed
//            expected beats, per-instance monitors pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_mux;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic [1:0] c;
  } beat_t;

  logic clk;
  logic rst;

  logic [1:0]  rr_sel, fx_sel;
  logic [3:0]  rr_in_valid, rr_in_last, rr_in_ready;
  logic [3:0]  fx_in_valid, fx_in_last, fx_in_ready;
  logic [31:0] rr_in_data, fx_in_data;
  logic        rr_out_valid, rr_out_last, rr_out_ready;
  logic        fx_out_valid, fx_out_last, fx_out_ready;
  logic [7:0]  rr_out_data, fx_out_data;
  logic [1:0]  rr_out_chan, fx_out_chan;

  beat_t q_rr[$];
  beat_t q_fx[$];

  int checks = 0;
  int errors = 0;

  rr_stream_mux #(.N(4), .W(8), .MODE(0)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .sel       (rr_sel),
    .in_valid  (rr_in_valid),
    .in_last   (rr_in_last),
    .in_data   (rr_in_data),
    .in_ready  (rr_in_ready),
    .out_valid (rr_out_valid),
    .out_data  (rr_out_data),
    .out_last  (rr_out_last),
    .out_chan  (rr_out_chan),
    .out_ready (rr_out_ready)
  );

  rr_stream_mux #(.N(4), .W(8), .MODE(1)) u_fx (
    .clk       (clk),
    .rst       (rst),
    .sel       (fx_sel),
    .in_valid  (fx_in_valid),
    .in_last   (fx_in_last),
    .in_data   (fx_in_data),
    .in_ready  (fx_in_ready),
    .out_valid (fx_out_valid),
    .out_data  (fx_out_data),
    .out_last  (fx_out_last),
    .out_chan  (fx_out_chan),
    .out_ready (fx_out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_rr(input logic [3:0] v, input logic [3:0] l,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    rr_in_valid = v;
    rr_in_last  = l;
    rr_in_data  = {d3, d2, d1, d0};
  endtask

  task automatic set_fx(input logic [3:0] v, input logic [3:0] l,
                        input logic [7:0] d0, input logic [7:0] d1,
                        input logic [7:0] d2, input logic [7:0] d3);
    fx_in_valid = v;
    fx_in_last  = l;
    fx_in_data  = {d3, d2, d1, d0};
  endtask

  // Wait to mid-cycle for checking.
  task automatic to_neg();
    @(negedge clk);
  endtask

  // Advance to just after the next rising edge for driving.
  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  // Round-robin instance monitor.
  always @(negedge clk) begin
    if (rr_out_valid === 1'b1 && rr_out_ready === 1'b1) begin
      if (q_rr.size() == 0) begin
        chk("rr_unexpected_beat", {22'd0, rr_out_data, rr_out_last, rr_out_chan}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = q_rr.pop_front();
        chk("rr_out_data", {24'd0, rr_out_data}, {24'd0, e.d});
        chk("rr_out_last", {31'd0, rr_out_last}, {31'd0, e.l});
        chk("rr_out_chan", {30'd0, rr_out_chan}, {30'd0, e.c});
      end
    end
  end

  // Fixed-select instance monitor.
  always @(negedge clk) begin
    if (fx_out_valid === 1'b1 && fx_out_ready === 1'b1) begin
      if (q_fx.size() == 0) begin
        chk("fx_unexpected_beat", {22'd0, fx_out_data, fx_out_last, fx_out_chan}, 32'hFFFF_FFFF);
      end else begin
        beat_t e;
        e = q_fx.pop_front();
        chk("fx_out_data", {24'd0, fx_out_data}, {24'd0, e.d});
        chk("fx_out_last", {31'd0, fx_out_last}, {31'd0, e.l});
        chk("fx_out_chan", {30'd0, fx_out_chan}, {30'd0, e.c});
      end
    end
  end

  initial begin
    beat_t b;
    logic [3:0] one;
    rst          = 1'b1;
    rr_sel       = 2'd0;
    fx_sel       = 2'd0;
    rr_out_ready = 1'b1;
    fx_out_ready = 1'b1;
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    set_fx(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_drive();
    to_drive();
    rst = 1'b0;

    // Reset state of both instances.
    to_neg();
    chk("rst_rr_out_valid", {31'd0, rr_out_valid}, 32'd0);
    chk("rst_rr_out_data",  {24'd0, rr_out_data},  32'd0);
    chk("rst_rr_out_last",  {31'd0, rr_out_last},  32'd0);
    chk("rst_rr_out_chan",  {30'd0, rr_out_chan},  32'd0);
    chk("rst_fx_out_valid", {31'd0, fx_out_valid}, 32'd0);
    chk("rst_fx_out_chan",  {30'd0, fx_out_chan},  32'd0);
    to_drive();

    // Round-robin rotation with single-beat packets on every channel.
    set_rr(4'b1111, 4'b1111, 8'h10, 8'h11, 8'h12, 8'h13);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      one = 4'b0001 << (k % 4);
      chk("t1_in_ready", {28'd0, rr_in_ready}, {28'd0, one});
      b.d = 8'h10 + 8'(k % 4); b.l = 1'b1; b.c = 2'(k % 4);
      q_rr.push_back(b);
      to_drive();
    end
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_neg();
    chk("t1_idle_in_ready", {28'd0, rr_in_ready}, 32'd0);
    to_drive();

    // 3-beat packet on ch1 with ch0/ch2 competing; pointer now at 1.
    set_rr(4'b0111, 4'b0101, 8'h40, 8'h21, 8'h30, 8'h00);
    to_neg();
    chk("t2_beat1_ready", {28'd0, rr_in_ready}, 32'h2);
    b.d = 8'h21; b.l = 1'b0; b.c = 2'd1; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0111, 4'b0101, 8'h40, 8'h22, 8'h30, 8'h00);
    to_neg();
    chk("t2_beat2_ready", {28'd0, rr_in_ready}, 32'h2);
    b.d = 8'h22; b.l = 1'b0; b.c = 2'd1; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0111, 4'b0111, 8'h40, 8'h23, 8'h30, 8'h00);
    to_neg();
    chk("t2_beat3_ready", {28'd0, rr_in_ready}, 32'h2);
    b.d = 8'h23; b.l = 1'b1; b.c = 2'd1; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0101, 4'b0101, 8'h40, 8'h00, 8'h30, 8'h00);
    to_neg();
    chk("t2_next_ch2_ready", {28'd0, rr_in_ready}, 32'h4);
    b.d = 8'h30; b.l = 1'b1; b.c = 2'd2; q_rr.push_back(b);
    to_drive();
    to_neg();
    chk("t2_wrap_ch0_ready", {28'd0, rr_in_ready}, 32'h1);
    b.d = 8'h40; b.l = 1'b1; b.c = 2'd0; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_drive();

    // Backpressure: hold a beat for 5 cycles, then drain and load together.
    rr_out_ready = 1'b0;
    set_rr(4'b0010, 4'b0010, 8'h00, 8'h51, 8'h00, 8'h00);
    to_neg();
    chk("t4_load_ready", {28'd0, rr_in_ready}, 32'h2);
    b.d = 8'h51; b.l = 1'b1; b.c = 2'd1; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0010, 4'b0010, 8'h00, 8'h52, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      to_neg();
      chk("t4_hold_ready", {28'd0, rr_in_ready}, 32'd0);
      chk("t4_hold_data", {24'd0, rr_out_data}, 32'h51);
      chk("t4_hold_valid", {31'd0, rr_out_valid}, 32'd1);
      to_drive();
    end
    rr_out_ready = 1'b1;
    to_neg();
    chk("t4_release_ready", {28'd0, rr_in_ready}, 32'h2);
    b.d = 8'h52; b.l = 1'b1; b.c = 2'd1; q_rr.push_back(b);
    to_drive();

    // Idle: nothing valid, held beat drains, data keeps its last value.
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    for (int k = 0; k < 3; k++) begin
      to_neg();
      chk("t6_in_ready", {28'd0, rr_in_ready}, 32'd0);
      if (k > 0) begin
        chk("t6_out_valid", {31'd0, rr_out_valid}, 32'd0);
        chk("t6_out_data", {24'd0, rr_out_data}, 32'h52);
      end
      to_drive();
    end

    // Reset while locked on ch2 with a beat held (pointer at 2).
    set_rr(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h62, 8'h00);
    to_neg();
    chk("t5_lock_ready", {28'd0, rr_in_ready}, 32'h4);
    b.d = 8'h62; b.l = 1'b0; b.c = 2'd2; q_rr.push_back(b);
    to_drive();
    rst = 1'b1;
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_neg();
    chk("t5_pre_rst_valid", {31'd0, rr_out_valid}, 32'd1);
    to_drive();
    rst = 1'b0;
    set_rr(4'b1001, 4'b1001, 8'h70, 8'h00, 8'h00, 8'h73);
    to_neg();
    chk("t5_post_rst_valid", {31'd0, rr_out_valid}, 32'd0);
    chk("t5_post_rst_chan", {30'd0, rr_out_chan}, 32'd0);
    chk("t5_first_grant_ch0", {28'd0, rr_in_ready}, 32'h1);
    b.d = 8'h70; b.l = 1'b1; b.c = 2'd0; q_rr.push_back(b);
    to_drive();
    set_rr(4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h73);
    to_neg();
    chk("t5_grant_ch3", {28'd0, rr_in_ready}, 32'h8);
    b.d = 8'h73; b.l = 1'b1; b.c = 2'd3; q_rr.push_back(b);
    to_drive();
    set_rr(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_drive();

    // Fixed select: sel=2, then sel moves to 3 mid-packet.
    fx_sel = 2'd2;
    set_fx(4'b1111, 4'b1011, 8'hA0, 8'hA1, 8'hA5, 8'hB3);
    to_neg();
    chk("t3_sel2_ready", {28'd0, fx_in_ready}, 32'h4);
    b.d = 8'hA5; b.l = 1'b0; b.c = 2'd2; q_fx.push_back(b);
    to_drive();
    fx_sel = 2'd3;
    set_fx(4'b1111, 4'b1011, 8'hA0, 8'hA1, 8'hA6, 8'hB3);
    to_neg();
    chk("t3_locked_ready", {28'd0, fx_in_ready}, 32'h4);
    b.d = 8'hA6; b.l = 1'b0; b.c = 2'd2; q_fx.push_back(b);
    to_drive();
    set_fx(4'b1111, 4'b1111, 8'hA0, 8'hA1, 8'hA7, 8'hB3);
    to_neg();
    chk("t3_last_ready", {28'd0, fx_in_ready}, 32'h4);
    b.d = 8'hA7; b.l = 1'b1; b.c = 2'd2; q_fx.push_back(b);
    to_drive();
    to_neg();
    chk("t3_sel3_ready", {28'd0, fx_in_ready}, 32'h8);
    b.d = 8'hB3; b.l = 1'b1; b.c = 2'd3; q_fx.push_back(b);
    to_drive();
    fx_sel = 2'd1;
    set_fx(4'b1101, 4'b1111, 8'hA0, 8'hA1, 8'hA7, 8'hB3);
    to_neg();
    chk("t3_sel_invalid_ready", {28'd0, fx_in_ready}, 32'd0);
    to_drive();
    to_neg();
    chk("t3_fx_drained", {31'd0, fx_out_valid}, 32'd0);
    to_drive();
    set_fx(4'b0, 4'b0, 8'h0, 8'h0, 8'h0, 8'h0);
    to_drive();
    to_drive();

    chk("rr_queue_empty", q_rr.size(), 32'd0);
    chk("fx_queue_empty", q_fx.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
